// File: rtl/spi_pkg.sv
// Shared SPI constants and state encoding for the slave transmitter
// and the ADC SPI receiver.
package spi_pkg;

    localparam int SPI_WORD_BITS   = 16;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_NSS
    } spi_tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage pin synchroniser with registered-level edge pulses.
// Edges compare the last stage with its one-cycle-delayed copy.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   STAGES      = SPI_SYNC_STAGES,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_LEVEL}};
            prev_q <= RESET_LEVEL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter, MSB first, one-deep holding register.
// Define SPI_TX_TRISTATE_EN to release MISO while NSS is high.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int WORD_BITS   = SPI_WORD_BITS,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 spi_nss,
    input  logic                 spi_clock_in,
    output logic                 spi_data_out,
    input  logic [WORD_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx_abort,
    output logic                 tx_underrun
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS - 1);

    spi_tx_state_t        state_q, state_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [WORD_BITS-1:0] word_q, word_d;
    logic [WORD_BITS-1:0] hold_q, hold_d;
    logic [WORD_BITS-1:0] last_q, last_d;
    logic                 hold_full_q, hold_full_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 miso_q, miso_d;
    logic                 done_q, done_d;
    logic                 abort_q, abort_d;
    logic                 under_q, under_d;

    logic nss_level, nss_rise, nss_fall;
    logic sck_level_unused, sck_rise, sck_fall;

    spi_sync_edge #(
        .STAGES     (SYNC_STAGES),
        .RESET_LEVEL(1'b1)
    ) u_nss_sync (
        .clock(clock),
        .reset(reset),
        .pin  (spi_nss),
        .level(nss_level),
        .rise (nss_rise),
        .fall (nss_fall)
    );

    spi_sync_edge #(
        .STAGES     (SYNC_STAGES),
        .RESET_LEVEL(1'b0)
    ) u_sck_sync (
        .clock(clock),
        .reset(reset),
        .pin  (spi_clock_in),
        .level(sck_level_unused),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        word_d      = word_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        under_d     = 1'b0;

        // A load only lands when empty, so it never races the consume below.
        if (data_valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (nss_fall) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_d = last_q;
                        under_d = 1'b1;
                    end
                    word_d  = shift_d;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (nss_rise) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = WAIT_NSS;
                        end
                    end
                    if (sck_fall && cnt_q != '0) begin
                        shift_d = {shift_q[WORD_BITS-2:0], 1'b0};
                    end
                end
            end
            WAIT_NSS: begin
                if (nss_rise) begin
                    done_d  = 1'b1;
                    last_d  = word_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d == SHIFT) && !nss_level
                 && shift_d[WORD_BITS-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_q      <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            under_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            under_q     <= under_d;
        end
    end

    assign data_ready  = !hold_full_q;
    assign busy        = (state_q != IDLE);
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;
    assign tx_underrun = under_q;

`ifdef SPI_TX_TRISTATE_EN
    assign spi_data_out = (nss_level || reset) ? 1'bz : miso_q;
`else
    assign spi_data_out = miso_q;
`endif

endmodule
